// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Instruction memory with a byte-stream program loader. A load begins with a
// one-cycle start pulse. The first accepted byte is a header that gives the
// word count N. The next 4*N bytes are assembled little-endian into 32-bit
// words, which are written to consecutive addresses from word 0 upward. While
// a load is in progress the CPU is stalled through cpu_hold. The CPU reads the
// memory combinationally through pc at all times.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset; clears the control state and
//                 zeroes the whole memory
//   start         one-cycle request to begin a load (ignored while loading)
//   abort         one-cycle request to cancel a load in progress
//   byte_in       program stream byte
//   byte_valid    byte_in is valid
//   byte_ready    loader accepts byte_in this cycle (HDR and LOAD states)
//   pc            CPU byte address; pc[1:0] are ignored
//   instruction   word at pc, or zero when pc is beyond the memory
//   cpu_hold      CPU must stall (HDR and LOAD states)
//   done          last load completed (level, cleared by start or rst)
//   error         last load rejected on its header (level, cleared by start/rst)
//   words_loaded  words written by the current or last load
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    input  logic [31:0]   pc,
    output logic [31:0]   instruction,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output logic [AW:0]   words_loaded
);

    localparam int NW = AW + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        LOAD = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   words_q, words_d;
    logic [AW:0]   n_q, n_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [23:0]   part_q, part_d;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];

    logic          xfer;
    logic          hdr_bad;
    logic [AW:0]   words_inc;

    // A byte moves only when both sides agree on the same edge.
    assign xfer      = byte_valid && byte_ready;
    assign hdr_bad   = (byte_in == 8'd0) || (32'(byte_in) > 32'(DEPTH));
    assign words_inc = words_q + 1'b1;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        words_d = words_q;
        n_d     = n_q;
        bcnt_d  = bcnt_q;
        part_d  = part_q;
        mem_d   = mem_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                // abort has no meaning here; only start leaves these states.
                if (start) begin
                    state_d = HDR;
                    words_d = '0;
                    n_d     = '0;
                    bcnt_d  = '0;
                    part_d  = '0;
                end
            end

            HDR: begin
                // abort wins over a byte offered on the same edge.
                if (abort) begin
                    state_d = IDLE;
                end else if (xfer) begin
                    if (hdr_bad) begin
                        state_d = ERR;
                    end else begin
                        n_d     = NW'(byte_in);
                        state_d = LOAD;
                    end
                end
            end

            LOAD: begin
                if (abort) begin
                    // Drop the partial word; words already written stay put
                    // and words_loaded keeps reporting them.
                    state_d = IDLE;
                    bcnt_d  = '0;
                    part_d  = '0;
                end else if (xfer) begin
                    if (bcnt_q == 2'd3) begin
                        mem_d[words_q[AW-1:0]] = {byte_in, part_q};
                        words_d = words_inc;
                        bcnt_d  = '0;
                        part_d  = '0;
                        if (words_inc == n_q) begin
                            state_d = DONE;
                        end
                    end else begin
                        case (bcnt_q)
                            2'd0:    part_d[7:0]   = byte_in;
                            2'd1:    part_d[15:8]  = byte_in;
                            default: part_d[23:16] = byte_in;
                        endcase
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and memory registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            words_q <= '0;
            n_q     <= '0;
            bcnt_q  <= '0;
            part_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            n_q     <= n_d;
            bcnt_q  <= bcnt_d;
            part_q  <= part_d;
            mem_q   <= mem_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        byte_ready   = (state_q == HDR) || (state_q == LOAD);
        cpu_hold     = (state_q == HDR) || (state_q == LOAD);
        done         = (state_q == DONE);
        error        = (state_q == ERR);
        words_loaded = words_q;
    end

    // The range check uses the full pc, so addresses past the memory read as
    // zero instead of aliasing onto low words.
    always_comb begin
        instruction = 32'h0;
        if (pc < 32'(4 * DEPTH)) begin
            instruction = mem_q[pc[AW+1:2]];
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader. Stimulus pushes expected values into a
// scoreboard queue; a monitor on the falling clock edge pops every queued
// entry and compares it against the selected DUT output.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  localparam int K_INSTR = 0;
  localparam int K_DONE  = 1;
  localparam int K_ERR   = 2;
  localparam int K_WORDS = 3;
  localparam int K_HOLD  = 4;
  localparam int K_READY = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic [31:0]   pc = 32'h0;
  logic [31:0]   instruction;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sb_q[$];
  item_t mon_it;
  logic [31:0] mon_act;
  int n_vec  = 0;
  int n_fail = 0;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .pc           (pc),
    .instruction  (instruction),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are stable half a cycle after the driving edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_it = sb_q.pop_front();
      case (mon_it.kind)
        K_INSTR: mon_act = instruction;
        K_DONE:  mon_act = {31'h0, done};
        K_ERR:   mon_act = {31'h0, error};
        K_WORDS: mon_act = {25'h0, words_loaded};
        K_HOLD:  mon_act = {31'h0, cpu_hold};
        default: mon_act = {31'h0, byte_ready};
      endcase
      n_vec = n_vec + 1;
      if (mon_act !== mon_it.exp) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: got %h, expected %h", mon_it.name, mon_act, mon_it.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expect_val(input int k, input logic [31:0] e, input string nm);
    item_t it;
    it.kind = k;
    it.exp  = e;
    it.name = nm;
    sb_q.push_back(it);
  endtask

  task automatic expect_status(input logic h, input logic d, input logic er,
                               input int w, input string nm);
    expect_val(K_HOLD,  {31'h0, h},  {nm, ".hold"});
    expect_val(K_READY, {31'h0, h},  {nm, ".ready"});
    expect_val(K_DONE,  {31'h0, d},  {nm, ".done"});
    expect_val(K_ERR,   {31'h0, er}, {nm, ".error"});
    expect_val(K_WORDS, 32'(w),      {nm, ".words"});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input logic [31:0] a, input logic [31:0] e, input string nm);
    pc = a;
    expect_val(K_INSTR, e, nm);
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  // Optional idle cycle after each byte, with junk on byte_in, to show
  // that bytes move only when byte_valid is high.
  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) begin
      send(w[8*i +: 8]);
      if (gap) begin
        byte_in = 8'hFF;
        tick();
      end
    end
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick();
    tick();
    rst = 1'b0;
    tick();
    expect_status(1'b0, 1'b0, 1'b0, 0, "reset");
    read_chk(32'd0,   32'h0, "reset.pc0");
    read_chk(32'd4,   32'h0, "reset.pc4");
    read_chk(32'd252, 32'h0, "reset.pc252");
    read_chk(32'd256, 32'h0, "reset.pc256");

    // ---------------- basic two-word load ----------------
    pulse_start();
    expect_status(1'b1, 1'b0, 1'b0, 0, "load2.hdr");
    send(8'h02);
    send_word(32'h0000_0013, 1'b0);
    expect_val(K_WORDS, 32'd1, "load2.words_mid");
    expect_val(K_HOLD,  32'd1, "load2.hold_mid");
    send(8'h93); send(8'h00); send(8'h10);
    expect_val(K_HOLD, 32'd1, "load2.hold_before_last");
    send(8'h00);
    if (done !== 1'b1 || words_loaded !== 7'd2) begin
      n_fail = n_fail + 1;
      $display("FAIL load2.direct: done=%b words=%0d", done, words_loaded);
    end
    expect_status(1'b0, 1'b1, 1'b0, 2, "load2.end");
    read_chk(32'd0, 32'h0000_0013, "load2.mem0");
    read_chk(32'd4, 32'h0010_0093, "load2.mem1");
    read_chk(32'd7, 32'h0010_0093, "load2.mem1_unaligned");
    read_chk(32'd8, 32'h0,         "load2.mem2");

    // ---------------- bad headers ----------------
    pulse_start();
    expect_status(1'b1, 1'b0, 1'b0, 0, "hdr00.start");
    send(8'h00);
    if (error !== 1'b1 || byte_ready !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL hdr00.direct: error=%b ready=%b", error, byte_ready);
    end
    expect_status(1'b0, 1'b0, 1'b1, 0, "hdr00.err");
    read_chk(32'd0, 32'h0000_0013, "hdr00.mem0");
    pulse_start();
    send(8'h41);
    expect_status(1'b0, 1'b0, 1'b1, 0, "hdr41.err");
    read_chk(32'd4, 32'h0010_0093, "hdr41.mem1");
    pulse_abort();
    expect_val(K_ERR, 32'd1, "err.abort_ignored");
    pulse_start();
    send(8'h40);
    expect_status(1'b1, 1'b0, 1'b0, 0, "hdr40.load");
    pulse_abort();
    expect_status(1'b0, 1'b0, 1'b0, 0, "hdr40.abort");

    // ---------------- three words, gapped valid ----------------
    pulse_start();
    send(8'h03);
    byte_in = 8'hFF;
    tick();
    send_word(32'h1122_3344, 1'b1);
    send_word(32'hDEAD_BEEF, 1'b1);
    send(8'h0D); tick();
    send(8'h0C); tick();
    send(8'h0B); tick();
    expect_status(1'b1, 1'b0, 1'b0, 2, "gap.before_last");
    send(8'h0A);
    expect_status(1'b0, 1'b1, 1'b0, 3, "gap.end");
    read_chk(32'd0,  32'h1122_3344, "gap.mem0");
    read_chk(32'd4,  32'hDEAD_BEEF, "gap.mem1");
    read_chk(32'd8,  32'h0A0B_0C0D, "gap.mem2");
    read_chk(32'd12, 32'h0,         "gap.mem3");

    // ---------------- abort after 6 bytes ----------------
    pulse_start();
    send(8'h02);
    send_word(32'h5566_7788, 1'b0);
    send(8'h01); send(8'h02);
    pulse_abort();
    expect_status(1'b0, 1'b0, 1'b0, 1, "abort6");
    read_chk(32'd0, 32'h5566_7788, "abort6.mem0");
    read_chk(32'd4, 32'hDEAD_BEEF, "abort6.mem1");

    // abort on the edge that would complete word 1
    pulse_start();
    send(8'h02);
    send_word(32'h1234_5678, 1'b0);
    send(8'h01); send(8'h02); send(8'h03);
    abort      = 1'b1;
    byte_valid = 1'b1;
    byte_in    = 8'h04;
    tick();
    abort      = 1'b0;
    byte_valid = 1'b0;
    expect_status(1'b0, 1'b0, 1'b0, 1, "abort_coinc");
    read_chk(32'd0, 32'h1234_5678, "abort_coinc.mem0");
    read_chk(32'd4, 32'hDEAD_BEEF, "abort_coinc.mem1");

    // a fresh load must not see the discarded partial bytes
    pulse_start();
    send(8'h01);
    send_word(32'hDDCC_BBAA, 1'b0);
    expect_status(1'b0, 1'b1, 1'b0, 1, "fresh");
    read_chk(32'd0, 32'hDDCC_BBAA, "fresh.mem0");

    // ---------------- start ignored, then rst mid-load ----------------
    pulse_start();
    send(8'h04);
    send_word(32'h0102_0304, 1'b0);
    send_word(32'h0506_0708, 1'b0);
    pulse_start();
    expect_status(1'b1, 1'b0, 1'b0, 2, "start_in_load");
    send(8'h09);
    pc = 32'd4;
    #1;
    rst = 1'b1;
    #1;
    if (cpu_hold !== 1'b0 || instruction !== 32'h0) begin
      n_fail = n_fail + 1;
      $display("FAIL rst_async.direct: hold=%b instr=%h", cpu_hold, instruction);
    end
    // No rising edge occurs before the monitor samples these.
    expect_status(1'b0, 1'b0, 1'b0, 0, "rst_async");
    expect_val(K_INSTR, 32'h0, "rst_async.mem1");
    tick();
    tick();
    rst = 1'b0;
    read_chk(32'd0, 32'h0, "rst.mem0");
    read_chk(32'd8, 32'h0, "rst.mem2");
    expect_status(1'b0, 1'b0, 1'b0, 0, "rst.idle");
    tick();

    tick();
    tick();
    if (n_vec == 0) begin
      n_fail = n_fail + 1;
      $display("FAIL no vectors were checked");
    end
    if (n_fail != 0) begin
      $display("FAIL summary: %0d miscompares", n_fail);
    end else begin
      $display("PASS");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
